// File: rtl/bfp_block_controller_pkg.sv
// Shared constants, state encoding and helper functions for the
// block-floating-point block controller and its divider.
package bfp_block_controller_pkg;

    localparam int DATA_W     = 32;
    localparam int SF_W       = 12;
    localparam int BLOCK_SIZE = 1024;
    localparam int MAX_Q      = 2047;
    localparam int MAX_SF     = 4095;
    localparam int ADDR_W     = $clog2(BLOCK_SIZE);
    // Dividend is peak + (MAX_Q-1), which needs one bit more than a sample.
    localparam int DIV_W      = DATA_W + 1;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DIV   = 2'd1,
        DRAIN = 2'd2
    } bfp_ctrl_state_t;

    // Magnitude as an unsigned DATA_W value, so the most negative sample
    // maps to 2^(DATA_W-1) instead of overflowing.
    function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] x);
        if (x[DATA_W-1]) begin
            abs_mag = ~x + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            abs_mag = x;
        end
    endfunction

    // Clamp the rounded-up quotient into the legal range [1, MAX_SF].
    function automatic logic [SF_W-1:0] sf_from_quotient(input logic [DIV_W-1:0] q);
        if (q == {DIV_W{1'b0}}) begin
            sf_from_quotient = SF_W'(1);
        end else if (q > DIV_W'(MAX_SF)) begin
            sf_from_quotient = SF_W'(MAX_SF);
        end else begin
            sf_from_quotient = q[SF_W-1:0];
        end
    endfunction

endpackage

// File: rtl/bfp_block_controller_seq_divider.sv
// Sequential restoring divider, one quotient bit per step.
// Ports: clk, rst_n (async active-low), start (ignored while busy),
//        dividend[N], divisor[M], busy, done (one-cycle pulse),
//        quotient[N] (registered, valid with done and held afterwards).
// Done is seen N-1 cycles after the start cycle (N cycles counting the
// start cycle itself): the start edge performs the first two steps.
module seq_divider #(
    parameter int N = 33,
    parameter int M = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);

    localparam int CNT_W = $clog2(N + 1);

    logic [N-1:0]     dq_r;
    logic [M-1:0]     rem_r;
    logic [M-1:0]     dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [M+N-1:0]   first_s;
    logic [M+N-1:0]   second_s;
    logic [M+N-1:0]   iter_s;

    // One restoring step: shift the next dividend bit into the remainder,
    // subtract if it fits, and shift the quotient bit into the LSB of dq.
    function automatic logic [M+N-1:0] div_step(input logic [M-1:0] rem,
                                                input logic [N-1:0] dq,
                                                input logic [M-1:0] dvs);
        logic [M:0] trial;
        logic [M:0] diff;
        logic       qbit;
        trial = {rem, dq[N-1]};
        if (trial >= {1'b0, dvs}) begin
            diff = trial - {1'b0, dvs};
            qbit = 1'b1;
        end else begin
            diff = trial;
            qbit = 1'b0;
        end
        div_step = {diff[M-1:0], dq[N-2:0], qbit};
    endfunction

    // Step values for the start edge (two steps) and for each busy edge.
    always_comb begin
        first_s  = div_step({M{1'b0}}, dividend, divisor);
        second_s = div_step(first_s[M+N-1:N], first_s[N-1:0], divisor);
        iter_s   = div_step(rem_r, dq_r, dvs_r);
    end

    // Divider state: load on start, iterate while busy, pulse done at the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_r   <= {N{1'b0}};
            rem_r  <= {M{1'b0}};
            dvs_r  <= {M{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start && !busy_r) begin
            rem_r  <= second_s[M+N-1:N];
            dq_r   <= second_s[N-1:0];
            dvs_r  <= divisor;
            cnt_r  <= CNT_W'(N - 2);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= iter_s[M+N-1:N];
            dq_r  <= iter_s[N-1:0];
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = dq_r;

endmodule

// File: rtl/bfp_block_controller.sv
// Block-floating-point block controller: FILL writes a block into an external
// RAM while tracking peak magnitude, DIV computes sf = ceil(peak/MAX_Q)
// clamped to [1, MAX_SF], DRAIN reads the block out to the quantiser.
// Ports: clk, rst_n; input stream in_valid/in_ready/in_data; RAM write port
//        buf_wr_en/addr/data; RAM read port buf_rd_en/addr (1-cycle latency);
//        dn_ready credit; q_valid/q_first/q_last qualify RAM output data;
//        sf/sf_valid scaling factor; block_done pulse with the last sample.
module bfp_block_controller
    import bfp_block_controller_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     buf_wr_en,
    output logic [ADDR_W-1:0]        buf_wr_addr,
    output logic [DATA_W-1:0]        buf_wr_data,
    output logic                     buf_rd_en,
    output logic [ADDR_W-1:0]        buf_rd_addr,
    input  logic                     dn_ready,
    output logic                     q_valid,
    output logic                     q_first,
    output logic                     q_last,
    output logic [SF_W-1:0]          sf,
    output logic                     sf_valid,
    output logic                     block_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_SIZE - 1);

    bfp_ctrl_state_t   state_r;
    bfp_ctrl_state_t   next_state_s;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic [ADDR_W-1:0] rd_cnt_r;
    logic [DATA_W-1:0] peak_r;
    logic [DATA_W-1:0] mag_s;
    logic [SF_W-1:0]   sf_r;
    logic              sf_valid_r;
    logic              in_ready_r;
    logic              rd_done_r;
    logic              q_valid_r;
    logic              q_first_r;
    logic              q_last_r;
    logic              block_done_r;
    logic              accept_s;
    logic              wr_last_s;
    logic              rd_en_s;
    logic              drain_end_s;
    logic              div_start_s;
    logic              div_busy_s;
    logic              div_done_s;
    logic [DIV_W-1:0]  dividend_s;
    logic [DIV_W-1:0]  quotient_s;

    assign accept_s    = in_valid & in_ready_r;
    assign wr_last_s   = accept_s && (wr_cnt_r == LAST_ADDR);
    // rd_done_r blocks further reads once the last address has been issued.
    assign rd_en_s     = (state_r == DRAIN) && dn_ready && !rd_done_r;
    assign drain_end_s = (state_r == DRAIN) && q_valid_r && q_last_r;
    // Start once on DIV entry; done is a single pulse, so it also guards
    // against a second start in the cycle the result arrives.
    assign div_start_s = (state_r == DIV) && !div_busy_s && !div_done_s;
    assign mag_s       = abs_mag(in_data);
    // Adding MAX_Q-1 before a truncating divide gives the ceiling.
    assign dividend_s  = {1'b0, peak_r} + DIV_W'(MAX_Q - 1);

    seq_divider #(
        .N (DIV_W),
        .M (SF_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s),
        .dividend (dividend_s),
        .divisor  (SF_W'(MAX_Q)),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (quotient_s)
    );

    // Phase sequencing.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FILL: begin
                if (wr_last_s) begin
                    next_state_s = DIV;
                end else begin
                    next_state_s = FILL;
                end
            end
            DIV: begin
                if (div_done_s) begin
                    next_state_s = DRAIN;
                end else begin
                    next_state_s = DIV;
                end
            end
            DRAIN: begin
                if (drain_end_s) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = DRAIN;
                end
            end
            default: next_state_s = FILL;
        endcase
    end

    // State, counters, peak and scaling factor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= FILL;
            in_ready_r <= 1'b0;
            wr_cnt_r   <= {ADDR_W{1'b0}};
            rd_cnt_r   <= {ADDR_W{1'b0}};
            rd_done_r  <= 1'b0;
            peak_r     <= {DATA_W{1'b0}};
            sf_r       <= {SF_W{1'b0}};
            sf_valid_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            // Registered so it stays low during reset and rises one cycle later.
            in_ready_r <= (next_state_s == FILL);
            if (accept_s) begin
                wr_cnt_r <= wr_cnt_r + ADDR_W'(1);
            end
            if (drain_end_s) begin
                peak_r <= {DATA_W{1'b0}};
            end else if (accept_s && (mag_s > peak_r)) begin
                peak_r <= mag_s;
            end
            if (rd_en_s) begin
                rd_cnt_r <= rd_cnt_r + ADDR_W'(1);
            end
            if (drain_end_s) begin
                rd_done_r <= 1'b0;
            end else if (rd_en_s && (rd_cnt_r == LAST_ADDR)) begin
                rd_done_r <= 1'b1;
            end
            // sf is kept after the drain until the next block overwrites it.
            if ((state_r == DIV) && div_done_s) begin
                sf_r       <= sf_from_quotient(quotient_s);
                sf_valid_r <= 1'b1;
            end else if (drain_end_s) begin
                sf_valid_r <= 1'b0;
            end
        end
    end

    // Output qualifiers aligned with the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid_r    <= 1'b0;
            q_first_r    <= 1'b0;
            q_last_r     <= 1'b0;
            block_done_r <= 1'b0;
        end else begin
            q_valid_r    <= rd_en_s;
            q_first_r    <= rd_en_s && (rd_cnt_r == {ADDR_W{1'b0}});
            q_last_r     <= rd_en_s && (rd_cnt_r == LAST_ADDR);
            block_done_r <= rd_en_s && (rd_cnt_r == LAST_ADDR);
        end
    end

    assign in_ready    = in_ready_r;
    assign buf_wr_en   = accept_s;
    assign buf_wr_addr = wr_cnt_r;
    assign buf_wr_data = accept_s ? in_data : {DATA_W{1'b0}};
    assign buf_rd_en   = rd_en_s;
    assign buf_rd_addr = rd_cnt_r;
    assign q_valid     = q_valid_r;
    assign q_first     = q_first_r;
    assign q_last      = q_last_r;
    assign sf          = sf_r;
    assign sf_valid    = sf_valid_r;
    assign block_done  = block_done_r;

endmodule

// File: doc/bfp_block_controller.md
Name: bfp_block_controller

Overview:
- Sequences the block-floating-point compression datapath, one block of BLOCK_SIZE signed samples at a time.
- FILL phase: writes incoming samples into an external single-port-per-side block RAM and tracks the block's peak magnitude.
- SCALE phase: computes the 12-bit scaling factor ceil(peak/MAX_Q), clamped to [1, MAX_SF].
- DRAIN phase: reads the buffered block out to the downstream quantiser with sf held stable; sits between the input stream and the quantiser.

Parameters:
- DATA_W, 32, sample width (signed)
- SF_W, 12, scaling-factor width
- BLOCK_SIZE, 1024, samples per block (power of two, ≥2)
- MAX_Q, 2047, largest quantised magnitude
- MAX_SF, 4095, largest scaling factor
- ADDR_W, $clog2(BLOCK_SIZE), buffer address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  controller accepts sample (high only in FILL)
- in_data  in  DATA_W  signed input sample
- buf_wr_en  out  1  buffer write strobe
- buf_wr_addr  out  ADDR_W  buffer write address
- buf_wr_data  out  DATA_W  buffer write data
- buf_rd_en  out  1  buffer read strobe (RAM read latency fixed at 1 cycle)
- buf_rd_addr  out  ADDR_W  buffer read address
- dn_ready  in  1  downstream credit: high in cycle t means a sample may be presented in t+1
- q_valid  out  1  buffer data on RAM output is valid this cycle
- q_first  out  1  with q_valid: first sample of block
- q_last  out  1  with q_valid: last sample of block
- sf  out  SF_W  scaling factor of block being drained
- sf_valid  out  1  sf valid (whole DRAIN phase)
- block_done  out  1  one-cycle pulse with the last q_valid

Behaviour:
- Reset (async assert, sync deassert by the system):
  - State FILL, counters 0, peak 0, sf 0.
  - All strobes and flags 0; in_ready asserts the first cycle after reset release.
  - Reset mid-block discards the partial block; no block_done.
- FILL:
  - in_ready=1. Handshake accept = in_valid & in_ready.
  - On accept, same cycle: buf_wr_en=1, buf_wr_addr=wr_cnt, buf_wr_data=in_data (combinational pass-through).
  - peak <= max(peak, |in_data|). |x| is computed as unsigned DATA_W, so |−2^31| = 2^31 with no overflow.
  - wr_cnt increments on accept. in_valid gaps are allowed; no timeout.
  - On accept with wr_cnt==BLOCK_SIZE-1 (cycle L): wr_cnt wraps to 0, next state DIV, and in_ready drops from L+1.
- DIV:
  - Dividend = peak + (MAX_Q-1), DATA_W+1 bits unsigned. Divisor = MAX_Q.
  - Start pulse in L+1. The sequential restoring divider runs DATA_W+1 = 33 cycles; quotient is registered with done at L+33.
  - L+34: sf <= (q==0) ? 1 : (q > MAX_SF ? MAX_SF : q[SF_W-1:0]). State DRAIN, sf_valid=1 from L+34.
- DRAIN:
  - In any cycle with dn_ready=1: buf_rd_en=1, buf_rd_addr=rd_cnt, rd_cnt++.
  - Next cycle: q_valid=1, q_first when that read address was 0, q_last when it was BLOCK_SIZE-1.
  - dn_ready low means no read and therefore a bubble, never a stall of presented data.
  - sf and sf_valid are constant through DRAIN.
  - After the read of address BLOCK_SIZE-1 (cycle R), no further reads are issued.
  - R+1: q_valid, q_last and block_done=1. State FILL, rd_cnt=0, peak=0, sf_valid=0 from R+2, in_ready=1 from R+2.
  - sf retains its value in FILL until overwritten.
- Invariants:
  - Never simultaneous write and read. No accepted sample is lost.
  - Peak tracking covers exactly BLOCK_SIZE samples.
  - Counters wrap modulo BLOCK_SIZE.

Decomposition:
- Shared parameter package holds the block parameters above, a derived ADDR_W constant, and typedef enum logic [1:0] {FILL, DIV, DRAIN} bfp_ctrl_state_t.
- Sub-module seq_divider: parameters N (dividend width) and M (divisor width). Ports clk, rst_n, start, dividend, divisor, busy, done, quotient. Fixed latency of N cycles from start to done; restart during busy is ignored.

Test Plan:
- Block of 1024 zeros -> sf=1, sf_valid exactly 34 cycles after last accept, 1024 q_valid with q_first/q_last on addr 0/1023.
- Peak sample +2047 (others smaller) -> sf=1; repeat with a single −2048 -> sf=2.
- Peak 8382465 (=4095·2047) -> sf=4095; peak 8382466 -> sf=4095 (clamped); sample −2^31 -> sf=4095, no overflow.
- Random in_valid gaps and dn_ready toggling at 50% -> written data read back in order, bit-exact, block_done once per block, in_ready low throughout DIV/DRAIN.
- rst_n pulsed low mid-FILL (addr 500) and mid-DRAIN (addr 300) -> all outputs 0 immediately, next block starts at addr 0 with fresh peak.
- Two back-to-back blocks with peaks 5000 then 100 -> sf 3 then 1; in_ready rises the cycle after block_done.
